// File: rtl/multiword_add_seq_pkg.sv
// multiword_add_seq_pkg: shared constants for the multiword add/subtract sequencer
package multiword_add_seq_pkg;
  localparam int SLICE_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/multiword_add_seq_if.sv
// multiword_add_seq_if: request/result bundle between requester and sequencer
interface multiword_add_seq_if #(parameter int WORDS = 4);
  import multiword_add_seq_pkg::*;
  localparam int W = SLICE_W * WORDS;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/multiword_add_seq_loop_adder.sv
// loop_adder: the shared 8-bit ripple adder reused for every slice
module loop_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: WORDS x 8-bit add/subtract computed one slice per cycle on a shared adder
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  multiword_add_seq_if.slave bus
);
  localparam int W  = SLICE_W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [W-1:0]         opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic                 cout_q, cout_d, ovf_q, ovf_d;
  logic [SLICE_W-1:0]   add_sum;
  logic                 add_cout;
  logic                 run, last, accept;
  loop_adder u_add (
    .a    (opa_q[idx_q*SLICE_W +: SLICE_W]),
    .b    (opb_q[idx_q*SLICE_W +: SLICE_W]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );
  assign run    = state_q == ST_RUN;
  assign last   = idx_q == IW'(WORDS - 1);
  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = accept ? ST_RUN : run ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  // Subtraction is a + ~b + 1, so b is inverted at capture and the carry seeded with 1.
  always_comb begin
    opa_d   = accept ? bus.a : opa_q;
    opb_d   = accept ? (bus.sub ? ~bus.b : bus.b) : opb_q;
    carry_d = accept ? (bus.sub | bus.cin) : run ? add_cout : carry_q;
    idx_d   = accept ? '0 : run ? idx_q + IW'(1) : idx_q;
    cout_d  = (run && last) ? add_cout : cout_q;
    ovf_d   = (run && last) ? (opa_q[W-1] == opb_q[W-1]) && (add_sum[SLICE_W-1] != opa_q[W-1]) : ovf_q;
    sum_d   = accept ? '0 : sum_q;
    if (run) sum_d[idx_q*SLICE_W +: SLICE_W] = add_sum;
  end
  always_comb begin
    bus.busy = run;
    bus.done = state_q == ST_DONE;
    bus.sum  = sum_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: randomized and directed checks against an arithmetic reference model
module tb_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int W = 8 * WORDS;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_sum = '0;
  logic last_cout = 1'b0;
  logic last_ovf = 1'b0;
  multiword_add_seq_if #(.WORDS(WORDS)) bus ();
  multiword_add_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin,
                       output logic [W-1:0] s, output logic c, output logic o);
    logic [W:0] full;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s = full[W-1:0];
      c = full[W];
      o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      s = a - b;
      c = a >= b;
      o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end
  endtask
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    bus.a = a;
    bus.b = b;
    bus.sub = sub;
    bus.cin = cin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    logic [W-1:0] es;
    logic ec, eo;
    model(a, b, sub, cin, es, ec, eo);
    check("sum_clear", 64'(bus.sum), 64'(0));
    check("cout_hold", 64'(bus.cout), 64'(last_cout));
    check("ovf_hold", 64'(bus.ovf), 64'(last_ovf));
    for (int k = 1; k <= WORDS; k++) begin
      check("busy_run", 64'(bus.busy), 64'(1));
      check("done_early", 64'(bus.done), 64'(0));
      @(negedge clk);
    end
    check("done", 64'(bus.done), 64'(1));
    check("busy_done", 64'(bus.busy), 64'(0));
    check("sum", 64'(bus.sum), 64'(es));
    check("cout", 64'(bus.cout), 64'(ec));
    check("ovf", 64'(bus.ovf), 64'(eo));
    last_sum = es;
    last_cout = ec;
    last_ovf = eo;
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    launch(a, b, sub, cin);
    finish_op(a, b, sub, cin);
  endtask
  task automatic idle_check();
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'(0));
    check("busy_idle", 64'(bus.busy), 64'(0));
    check("sum_held", 64'(bus.sum), 64'(last_sum));
    check("cout_held", 64'(bus.cout), 64'(last_cout));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_cout", 64'(bus.cout), 64'(0));
    check("rst_ovf", 64'(bus.ovf), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    idle_check();
    op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    idle_check();
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle_check();
    op(32'd10, 32'd5, 1'b1, 1'b0);
    idle_check();
    op(32'd5, 32'd10, 1'b1, 1'b0);
    idle_check();
    launch(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 32'd1;
    bus.b = 32'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_ignore", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check("done_ignore", 64'(bus.done), 64'(1));
    check("sum_ignore", 64'(bus.sum), 64'(32'hFFFF_FFFF));
    check("cout_ignore", 64'(bus.cout), 64'(0));
    last_sum = 32'hFFFF_FFFF;
    last_cout = 1'b0;
    last_ovf = 1'b0;
    idle_check();
    idle_check();
    op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    check("b2b_prev", 64'(bus.sum), 64'(32'h3333_3333));
    op(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0);
    check("b2b_sum", 64'(bus.sum), 64'(32'h1E1E_1E1E));
    idle_check();
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 64'(bus.sum), 64'(0));
    check("mid_rst_cout", 64'(bus.cout), 64'(0));
    check("mid_rst_ovf", 64'(bus.ovf), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = '0;
    last_cout = 1'b0;
    last_ovf = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_rst", 64'(bus.done), 64'(0));
    end
    op(32'd1, 32'd1, 1'b0, 1'b0);
    check("post_rst_sum", 64'(bus.sum), 64'(2));
    idle_check();
    for (int i = 0; i < 40; i++) begin
      op(32'($urandom), 32'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) idle_check();
    end
    idle_check();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
